// File: rtl/fdiv_issue_ctrl.sv
// fdiv_issue_ctrl
// Issue/retire controller for a fixed-latency, non-stallable FP divide pipe.
// Each accepted request is launched into the pipe immediately. A valid/tag
// shift register follows every op through the pipe, and each result is
// captured into a response FIFO. Credits (ops in flight + FIFO occupancy)
// reserve a FIFO slot for every launched op, so the pipe never has to stall
// and no result is ever dropped.
// Optional feature macro: FDIV_DZ_FLAG_EN adds the resp_dz output. The flag
// marks a nonzero dividend divided by a zero or subnormal divisor.
module fdiv_issue_ctrl #(
    parameter int LATENCY = 7,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      pipe_x,
    output logic [31:0]      pipe_y,
    input  logic [31:0]      pipe_res,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
`ifdef FDIV_DZ_FLAG_EN
    ,
    output logic             resp_dz
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FDIV_DZ_FLAG_EN
    localparam int SW = TAG_W + 1;   // {dz, tag}
`else
    localparam int SW = TAG_W;       // tag only
`endif

    // Advance a FIFO pointer with wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

`ifdef FDIV_DZ_FLAG_EN
    // Divide-by-zero flag: divisor exponent zero (zero/subnormal) and dividend nonzero
    function automatic logic dz_detect(input logic [31:0] x, input logic [31:0] y);
        return (y[30:23] == 8'h00) && (x[30:0] != 31'd0);
    endfunction
`endif

    logic [LATENCY-1:0] vld_sr_r;
    logic [SW-1:0]      side_sr_r [LATENCY];
    logic [31:0]        mem_data_r [DEPTH];
    logic [SW-1:0]      mem_side_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      inflight_r;
    logic [CW-1:0]      count_r;
    logic               resp_valid_r;
    logic               busy_r;

    logic               launch_s;
    logic               push_s;
    logic               pop_s;
    logic [SW-1:0]      side_in_s;
    logic [CW-1:0]      inflight_nxt_s;
    logic [CW-1:0]      count_nxt_s;
    logic [CW:0]        credit_sum_s;

    // The pipe sees the request operands every cycle; non-launched slots are ignored
    assign pipe_x = req_x;
    assign pipe_y = req_y;

    // Handshake qualifiers and credit arithmetic from registered state only
    always_comb begin
        credit_sum_s   = {1'b0, inflight_r} + {1'b0, count_r};
        req_ready      = ~rst & (credit_sum_s < (CW + 1)'(DEPTH));
        launch_s       = req_valid & req_ready;
        push_s         = vld_sr_r[LATENCY-1];
        pop_s          = resp_valid_r & resp_ready;
        inflight_nxt_s = inflight_r + CW'(launch_s) - CW'(push_s);
        count_nxt_s    = count_r + CW'(push_s) - CW'(pop_s);
`ifdef FDIV_DZ_FLAG_EN
        side_in_s      = {dz_detect(req_x, req_y), req_tag};
`else
        side_in_s      = req_tag;
`endif
    end

    // Track launched ops through the pipe: valid bit plus side info per stage
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                side_sr_r[i] <= '0;
            end
        end else begin
            vld_sr_r[0]  <= launch_s;
            side_sr_r[0] <= side_in_s;
            for (int i = 1; i < LATENCY; i++) begin
                vld_sr_r[i]  <= vld_sr_r[i-1];
                side_sr_r[i] <= side_sr_r[i-1];
            end
        end
    end

    // Circular response FIFO; storage cleared on reset so the head never reads X
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_r[i] <= '0;
                mem_side_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= pipe_res;
                mem_side_r[wr_ptr_r] <= side_sr_r[LATENCY-1];
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

    // Credit counters and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r   <= '0;
            count_r      <= '0;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            inflight_r   <= inflight_nxt_s;
            count_r      <= count_nxt_s;
            resp_valid_r <= (count_nxt_s != CW'(0));
            busy_r       <= (inflight_nxt_s != CW'(0)) | (count_nxt_s != CW'(0));
        end
    end

    assign resp_valid = resp_valid_r;
    assign busy       = busy_r;
    assign resp_data  = mem_data_r[rd_ptr_r];
    assign resp_tag   = mem_side_r[rd_ptr_r][TAG_W-1:0];
`ifdef FDIV_DZ_FLAG_EN
    assign resp_dz    = resp_valid_r & mem_side_r[rd_ptr_r][TAG_W];
`endif

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// tb_fdiv_issue_ctrl
// Directed bench for fdiv_issue_ctrl with a behavioural 7-cycle divide pipe.
// The pipe model returns hand-known quotients for the directed operand pairs.
// Define FDIV_DZ_FLAG_EN to also exercise resp_dz.
module tb_fdiv_issue_ctrl;

    localparam int LATENCY = 7;
    localparam int DEPTH   = 8;
    localparam int TAG_W   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_x;
    logic [31:0]      req_y;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      pipe_x;
    logic [31:0]      pipe_y;
    logic [31:0]      pipe_res;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;
`ifdef FDIV_DZ_FLAG_EN
    logic             resp_dz;
`endif

    always #5 clk = ~clk;

    fdiv_issue_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_tag    (req_tag),
        .pipe_x     (pipe_x),
        .pipe_y     (pipe_y),
        .pipe_res   (pipe_res),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
`ifdef FDIV_DZ_FLAG_EN
        ,
        .resp_dz    (resp_dz)
`endif
    );

    // Quotients for the operand pairs used here (divide by 1.0 returns the dividend)
    function automatic logic [31:0] fdiv_ref(input logic [31:0] x, input logic [31:0] y);
        if (y == 32'h3F80_0000) return x;
        else if (x == 32'h40C0_0000 && y == 32'h4040_0000) return 32'h4000_0000;
        else if (x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h3F00_0000;
        else if (y[30:0] == 31'd0) return (x[30:0] == 31'd0) ? 32'h7FC0_0000 : {x[31] ^ y[31], 31'h7F80_0000};
        else return x ^ y;
    endfunction

    // Behavioural divide pipe: fixed latency, never stalls, no reset
    logic [31:0] pq [LATENCY];
    always @(posedge clk) begin
        pq[0] <= fdiv_ref(pipe_x, pipe_y);
        for (int i = 1; i < LATENCY; i++) pq[i] <= pq[i-1];
    end
    assign pipe_res = pq[LATENCY-1];

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_launch = 0;
    int   n_pop    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Advance one cycle; scoreboard the handshakes that complete at this edge
    task automatic tick();
        bit   launch;
        bit   pop;
        exp_t e;
        launch = req_valid & req_ready;
        pop    = resp_valid & resp_ready;
        if (pop) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check("spurious_resp", 64'd1, 64'd0);
            end else begin
                check("sb_tag", 64'(resp_tag), 64'(exp_q[0].tag));
                check("sb_data", 64'(resp_data), 64'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
        end
        if (launch) begin
            e.tag  = req_tag;
            e.data = fdiv_ref(req_x, req_y);
            exp_q.push_back(e);
            n_launch++;
        end
        @(posedge clk);
        #1;
        if (launch) begin
            req_tag = req_tag + 1'b1;
            req_x   = 32'h4100_0000 | {18'd0, req_tag, 8'd0};
        end
    endtask

    // Launch one request and wait for its response to reach the FIFO head
    task automatic single(input logic [31:0] x, input logic [31:0] y,
                          input logic [TAG_W-1:0] t, output int lat);
        req_x     = x;
        req_y     = y;
        req_tag   = t;
        req_valid = 1'b1;
        check("single_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        int nl;
        int vcnt;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_x      = 32'h0;
        req_y      = 32'h3F80_0000;
        req_tag    = '0;
        resp_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_resp_tag", 64'(resp_tag), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'd1);

        // 1: 6.0 / 3.0
        single(32'h40C0_0000, 32'h4040_0000, 6'd5, lat);
        check("t1_latency", 64'(lat), 64'd8);
        check("t1_data", 64'(resp_data), 64'h4000_0000);
        check("t1_tag", 64'(resp_tag), 64'd5);
        tick();
        check("t1_empty", 64'(resp_valid), 64'd0);

        // 2: eight back-to-back requests, full drain
        req_y     = 32'h3F80_0000;
        req_tag   = 6'd0;
        req_x     = 32'h4100_0000;
        req_valid = 1'b1;
        n0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            check("t2_ready", 64'(req_ready), 64'd1);
            tick();
        end
        req_valid = 1'b0;
        drain(40);
        check("t2_pops", 64'(n_pop - n0), 64'd8);

        // 3: consumer stalled, requests held valid
        resp_ready = 1'b0;
        req_tag    = 6'd10;
        req_x      = 32'h4100_0A00;
        req_valid  = 1'b1;
        n0 = n_launch;
        repeat (20) tick();
        check("t3_accepted", 64'(n_launch - n0), 64'd8);
        check("t3_ready_low", 64'(req_ready), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_head_valid", 64'(resp_valid), 64'd1);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        n0 = n_pop;
        tick();
        check("t3_ready_reassert", 64'(req_ready), 64'd1);
        drain(30);
        check("t3_pops", 64'(n_pop - n0), 64'd8);

        // 4: simultaneous push and pop with every credit in use
        resp_ready = 1'b0;
        req_tag    = 6'd20;
        req_x      = 32'h4100_1400;
        req_valid  = 1'b1;
        n0 = n_launch;
        repeat (20) tick();
        check("t4_fill", 64'(n_launch - n0), 64'd8);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();                       // pop tag 20
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        check("t4_ready", 64'(req_ready), 64'd1);
        nl = n_launch;
        tick();                       // launch tag 28
        check("t4_one_launch", 64'(n_launch - nl), 64'd1);
        repeat (6) tick();
        resp_ready = 1'b1;
        tick();                       // push tag 28 and pop tag 21 together
        resp_ready = 1'b0;
        nl = n_launch;
        repeat (12) tick();
        check("t4_single_credit", 64'(n_launch - nl), 64'd1);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        drain(40);

        // 5: reset while ops are in flight
        req_tag   = 6'd30;
        req_x     = 32'h4100_1E00;
        req_valid = 1'b1;
        repeat (4) tick();
        req_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t5_ready_in_rst", 64'(req_ready), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        #1;
        check("t5_ready_after", 64'(req_ready), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_resp_valid", 64'(resp_valid), 64'd0);
        check("t5_resp_data", 64'(resp_data), 64'd0);
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (resp_valid) vcnt++;
        end
        check("t5_no_stale_resp", 64'(vcnt), 64'd0);
        single(32'h4110_0000, 32'h3F80_0000, 6'd9, lat);
        check("t5_latency", 64'(lat), 64'd8);
        check("t5_tag", 64'(resp_tag), 64'd9);
        check("t5_data", 64'(resp_data), 64'h4110_0000);
        tick();
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (resp_valid) vcnt++;
        end
        check("t5_only_one", 64'(vcnt), 64'd0);

`ifdef FDIV_DZ_FLAG_EN
        // 6: divide-by-zero flag
        single(32'h3F80_0000, 32'h0000_0000, 6'd1, lat);
        check("t6_dz_1_0", 64'(resp_dz), 64'd1);
        check("t6_data_1_0", 64'(resp_data), 64'h7F80_0000);
        tick();
        single(32'h0000_0000, 32'h0000_0000, 6'd2, lat);
        check("t6_dz_0_0", 64'(resp_dz), 64'd0);
        tick();
        single(32'h3F80_0000, 32'h4000_0000, 6'd3, lat);
        check("t6_dz_1_2", 64'(resp_dz), 64'd0);
        check("t6_data_1_2", 64'(resp_data), 64'h3F00_0000);
        tick();
        check("t6_dz_idle", 64'(resp_dz), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
